sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Synchronous single-clock FIFO built around a 2**AW-entry register array, addressed by internal write and read pointers.
- Each pointer advances by exactly +1 on an accepted operation and wraps at 2**AW.
- Sits between the QuickQ producer logic and the downstream consumer, buffering data words.
- Generates the pointer enables, full/empty flags, occupancy count and registered read data.

Parameters:
W, 8, data word width in bits
AW, 4, address width; depth DEPTH = 2**AW entries
AF_LVL, 2**AW-2, almost-full threshold (used only with the optional feature)
AE_LVL, 1, almost-empty threshold (used only with the optional feature)

Ports:
clk  input  1  clock; all logic on its rising edge
rst  input  1  reset, synchronous, active-high
wr_en  input  1  write request
din  input  W  write data, sampled when the write is accepted
rd_en  input  1  read request
dout  output  W  registered read data
dout_vld  output  1  dout holds a newly read word this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  AW+1  occupancy, 0..DEPTH
ovf  output  1  sticky: write attempted while full
udf  output  1  sticky: read attempted while empty
almost_full  output  1  optional feature only
almost_empty  output  1  optional feature only

Behaviour:
- Reset (rst=1 at a clock edge):
  - wptr=0, rptr=0, count=0, empty=1, full=0.
  - dout=0, dout_vld=0, ovf=0, udf=0.
  - Array contents are not cleared.
  - Reset has priority over all requests, including mid-operation; data in flight is discarded.
- Acceptance rules, evaluated on the pre-edge state:
  - wr_ok = wr_en & ~full
  - rd_ok = rd_en & ~empty
  - Full with simultaneous read: the write is rejected and the read accepted; count becomes DEPTH-1.
  - Empty with simultaneous write: the read is rejected and the write accepted; count becomes 1. There is no bypass path.
- Write: on wr_ok, mem[wptr] <= din and wptr <= wptr+1, wrapping from DEPTH-1 to 0 (AW-bit modular).
- Read: on rd_ok, dout <= mem[rptr] and rptr <= rptr+1 (modular).
  - dout_vld=1 in the cycle after the accepted read; otherwise dout_vld=0.
  - dout holds its last value when no read is accepted.
  - Read latency: 1 clock from rd_en sampled to dout_vld.
- Count:
  - +1 on wr_ok only; -1 on rd_ok only; unchanged on both or neither.
  - full and empty are registered, derived from the next-count value, so both are valid in the same cycle as count.
- Error flags:
  - ovf sets on wr_en & full; udf sets on rd_en & empty.
  - Both hold until rst.
  - Rejected operations change no other state.
- Invariants, any cycle:
  - full & empty == 0
  - count == (wptr - rptr) mod DEPTH, except count == DEPTH when full
- Ordering: strictly first-in first-out; no reordering, no overwrite.

Optional Feature:
- Macro: SYNC_FIFO_ALMOST_FLAGS_EN
- Defined:
  - almost_full=1 iff count >= AF_LVL; almost_empty=1 iff count <= AE_LVL.
  - Both registered with count.
  - Reset values: almost_full=0, almost_empty=1.
- Undefined:
  - almost_full and almost_empty ports still exist and are tied to 0.
  - AF_LVL and AE_LVL are ignored; no threshold comparators are instantiated.

Test Plan:
1. Reset, then write 0x11,0x22,0x33 then read 3 (W=8, AW=2; same parameters for tests 2–6) -> dout 0x11,0x22,0x33 on 3 consecutive dout_vld cycles, each 1 clock after its rd_en; final count=0, empty=1.
2. Write 4 words, then wr_en with din=0x55 -> full=1, count=4, ovf=1, 0x55 never read out; reading 4 returns the original 4 words.
3. From empty, rd_en=1 and wr_en=1 with din=0xA5 in the same cycle -> udf=1, count=1, dout_vld=0; next read returns 0xA5.
4. From full, rd_en=1 and wr_en=1 in the same cycle -> read accepted, write rejected, count=3, ovf=1.
5. Pointer wrap: stream 10 writes interleaved with reads at count<=2 -> outputs match input order 0..9 across two wraps of wptr and rptr.
6. Assert rst for 1 cycle with count=3 and a read in flight -> next cycle count=0, empty=1, dout_vld=0, dout=0, ovf=udf=0. With SYNC_FIFO_ALMOST_FLAGS_EN, AF_LVL=3, AE_LVL=1: almost_full=1 at count 3–4 and almost_empty=1 at count 0–1.

Source files
------------

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO on a 2**AW-entry register array, with
//               registered read data, occupancy count, full/empty flags and
//               sticky overflow/underflow flags. Optional almost-full and
//               almost-empty flags are enabled by SYNC_FIFO_ALMOST_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int W      = 8,
  parameter int AW     = 4,
  parameter int AF_LVL = 2**AW - 2,
  parameter int AE_LVL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  din,
  input  logic          rd_en,
  output logic [W-1:0]  dout,
  output logic          dout_vld,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf,
  output logic          almost_full,
  output logic          almost_empty
);

  localparam int          c_DEPTH_INT = 2**AW;
  localparam logic [AW:0] c_DEPTH     = (AW+1)'(c_DEPTH_INT);
  localparam logic [AW:0] c_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

  logic [W-1:0]  r_mem [0:c_DEPTH_INT-1];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic [W-1:0]  r_dout;
  logic          r_dout_vld;
  logic          r_ovf;
  logic          r_udf;

  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [AW:0]   w_count_nxt;

  assign w_wr_ok = wr_en & ~r_full;
  assign w_rd_ok = rd_en & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + c_CNT_ONE;
      2'b01:   w_count_nxt = r_count - c_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage has no reset; a write coinciding with rst is discarded.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_rd_ok) begin
        r_dout <= r_mem[r_rptr];
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      r_dout_vld <= w_rd_ok;
      // Flags come from the next count so they line up with count itself.
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == c_DEPTH);
      r_empty    <= (w_count_nxt == '0);
      if (wr_en && r_full) begin
        r_ovf <= 1'b1;
      end
      if (rd_en && r_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign ovf      = r_ovf;
  assign udf      = r_udf;

`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  localparam logic [AW:0] c_AF_LVL = (AW+1)'(AF_LVL);
  localparam logic [AW:0] c_AE_LVL = (AW+1)'(AE_LVL);

  logic r_almost_full;
  logic r_almost_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (w_count_nxt >= c_AF_LVL);
      r_almost_empty <= (w_count_nxt <= c_AE_LVL);
    end
  end

  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
`else
  // Thresholds have no function in this build.
  localparam int c_unused_lvls = AF_LVL + AE_LVL;

  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Directed self-checking bench for sync_fifo (W=8, AW=2) with a
//               data scoreboard queue and a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  localparam int c_W     = 8;
  localparam int c_AW    = 2;
  localparam int c_DEPTH = 2**c_AW;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [c_W-1:0]   din;
  logic             rd_en;
  logic [c_W-1:0]   dout;
  logic             dout_vld;
  logic             full;
  logic             empty;
  logic [c_AW:0]    count;
  logic             ovf;
  logic             udf;
  logic             almost_full;
  logic             almost_empty;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [c_W-1:0] sb_q[$];
  int             m_count;
  bit             m_ovf;
  bit             m_udf;
  bit             m_vld;
  logic [c_W-1:0] m_dout;

  sync_fifo #(
    .W      (c_W),
    .AW     (c_AW),
    .AF_LVL (3),
    .AE_LVL (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_vld     (dout_vld),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .ovf          (ovf),
    .udf          (udf),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [c_W-1:0] exp_word;
    check({tag, " count"}, 32'(count), 32'(m_count));
    check({tag, " full"}, 32'(full), 32'(m_count == c_DEPTH));
    check({tag, " empty"}, 32'(empty), 32'(m_count == 0));
    check({tag, " ovf"}, 32'(ovf), 32'(m_ovf));
    check({tag, " udf"}, 32'(udf), 32'(m_udf));
    check({tag, " dout_vld"}, 32'(dout_vld), 32'(m_vld));
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    check({tag, " almost_full"}, 32'(almost_full), 32'(m_count >= 3));
    check({tag, " almost_empty"}, 32'(almost_empty), 32'(m_count <= 1));
`else
    check({tag, " almost_full"}, 32'(almost_full), 32'(0));
    check({tag, " almost_empty"}, 32'(almost_empty), 32'(0));
`endif
    if (dout_vld === 1'b1) begin
      if (sb_q.size() == 0) begin
        check({tag, " scoreboard underrun"}, 32'(1), 32'(0));
      end else begin
        exp_word = sb_q.pop_front();
        m_dout   = exp_word;
        check({tag, " dout"}, 32'(dout), 32'(exp_word));
      end
    end else begin
      check({tag, " dout hold"}, 32'(dout), 32'(m_dout));
    end
  endtask

  // One clock: drive inputs, update the model from pre-edge state, check after.
  task automatic step(input string tag, input bit wr, input logic [c_W-1:0] d, input bit rd);
    bit wr_ok, rd_ok;
    wr_en = wr;
    din   = d;
    rd_en = rd;
    wr_ok = wr && (m_count != c_DEPTH);
    rd_ok = rd && (m_count != 0);
    if (wr && m_count == c_DEPTH) m_ovf = 1'b1;
    if (rd && m_count == 0)       m_udf = 1'b1;
    if (wr_ok) sb_q.push_back(d);
    m_count = m_count + int'(wr_ok) - int'(rd_ok);
    m_vld   = rd_ok;
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag, input bit rd);
    rst   = 1'b1;
    wr_en = 1'b0;
    din   = '0;
    rd_en = rd;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    rd_en   = 1'b0;
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_vld   = 1'b0;
    m_dout  = '0;
    sb_q.delete();
    check_state(tag);
    check({tag, " dout zero"}, 32'(dout), 32'(0));
  endtask

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    @(posedge clk);
    #1;

    // Test 1: basic write 3 / read 3
    do_reset("t1 reset", 1'b0);
    step("t1 wr11", 1'b1, 8'h11, 1'b0);
    step("t1 wr22", 1'b1, 8'h22, 1'b0);
    step("t1 wr33", 1'b1, 8'h33, 1'b0);
    step("t1 rd0", 1'b0, 8'h00, 1'b1);
    step("t1 rd1", 1'b0, 8'h00, 1'b1);
    step("t1 rd2", 1'b0, 8'h00, 1'b1);
    step("t1 idle", 1'b0, 8'h00, 1'b0);

    // Test 2: fill, overflow attempt, drain
    do_reset("t2 reset", 1'b0);
    for (int i = 0; i < c_DEPTH; i++) step("t2 fill", 1'b1, 8'(8'hC0 + i), 1'b0);
    step("t2 ovf wr55", 1'b1, 8'h55, 1'b0);
    for (int i = 0; i < c_DEPTH; i++) step("t2 drain", 1'b0, 8'h00, 1'b1);
    step("t2 idle", 1'b0, 8'h00, 1'b0);

    // Test 3: simultaneous read+write while empty
    do_reset("t3 reset", 1'b0);
    step("t3 rdwr empty", 1'b1, 8'hA5, 1'b1);
    step("t3 rd", 1'b0, 8'h00, 1'b1);
    step("t3 idle", 1'b0, 8'h00, 1'b0);

    // Test 4: simultaneous read+write while full
    do_reset("t4 reset", 1'b0);
    for (int i = 0; i < c_DEPTH; i++) step("t4 fill", 1'b1, 8'(8'h40 + i), 1'b0);
    step("t4 rdwr full", 1'b1, 8'h99, 1'b1);
    step("t4 rdwr", 1'b1, 8'h77, 1'b1);
    for (int i = 0; i < c_DEPTH; i++) step("t4 drain", 1'b0, 8'h00, 1'b1);
    step("t4 underflow", 1'b0, 8'h00, 1'b1);

    // Test 5: pointer wrap with a streaming pattern
    do_reset("t5 reset", 1'b0);
    for (int i = 0; i < 10; i++) step("t5 stream", 1'b1, 8'(i), (m_count >= 1));
    while (m_count > 0) step("t5 drain", 1'b0, 8'h00, 1'b1);
    step("t5 idle", 1'b0, 8'h00, 1'b0);

    // Test 6: reset with a read in flight; almost flags across counts
    do_reset("t6 reset", 1'b0);
    step("t6 udf", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < c_DEPTH; i++) step("t6 fill", 1'b1, 8'(8'h60 + i), 1'b0);
    step("t6 ovf", 1'b1, 8'h66, 1'b0);
    step("t6 rd", 1'b0, 8'h00, 1'b1);
    do_reset("t6 mid reset", 1'b1);
    step("t6 after wr", 1'b1, 8'h5A, 1'b0);
    step("t6 after rd", 1'b0, 8'h00, 1'b1);
    step("t6 idle", 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
